// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared opcode, status and state encodings for debug_ctrl
//
// Purpose : one place for the host command opcodes, response status codes
//           and the debug controller state enumeration, so the controller
//           and anything talking to it agree on the encodings.
// Ports   : none (package).

package debug_pkg;

    // Host command opcodes carried on cmd_op.
    typedef enum logic [2:0] {
        OP_HALT    = 3'd0,
        OP_RESUME  = 3'd1,
        OP_STEP    = 3'd2,
        OP_RDREG   = 3'd3,
        OP_WRREG   = 3'd4,
        OP_RDPC    = 3'd5,
        OP_RDIR    = 3'd6,
        OP_RDFLAGS = 3'd7
    } op_e;

    // Response status codes carried on rsp_status.
    typedef enum logic [1:0] {
        STAT_OK         = 2'b00,
        STAT_NOT_HALTED = 2'b01,
        STAT_BAD_OP     = 2'b10
    } status_e;

    // Controller states.
    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_HALT_PEND = 3'd1,
        S_HALTED    = 3'd2,
        S_STEP_REL  = 3'd3,
        S_STEP_WAIT = 3'd4,
        S_RD_WAIT   = 3'd5,
        S_RESP      = 3'd6
    } state_e;

    // Width of the CPU flags bus {N,Z,C,V}.
    localparam int FLAGS_W = 4;

    // Commands that touch CPU state and are therefore refused while running.
    function automatic logic needs_halt(input op_e op);
        return (op == OP_STEP) || (op == OP_RDREG) || (op == OP_WRREG);
    endfunction

endpackage

// File: rtl/debug_ctrl.sv
// rtl/debug_ctrl.sv - host debug controller: halt/resume/step and state access for a CPU
//
// Purpose : accepts one host command at a time, stalls/releases the CPU at
//           instruction boundaries, reads/writes the register file through a
//           debug port and returns a single response per command.
// Ports   :
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_op, cmd_addr, cmd_data         opcode, register index, write data
//   rsp_valid/rsp_ready                response handshake
//   rsp_data, rsp_status               read data (0 for non-reads), status
//   ir_enable, ir, pc, flags           CPU fetch strobe and visible CPU state
//   cpu_stall                          freezes the CPU
//   rf_addr, rf_wdata, rf_we, rf_rdata debug register-file port (1-cycle read)

module debug_ctrl
    import debug_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    input  logic              ir_enable,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] pc,
    input  logic [3:0]        flags,
    output logic              cpu_stall,
    output logic [RA_W-1:0]   rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata
);

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    state_e              r_state;
    state_e              r_ret;        // state to enter once the response is taken
    logic                r_live;       // low during reset and the first cycle after
    logic [DATA_W-1:0]   r_rsp_data;
    logic [1:0]          r_rsp_status;
    logic [RA_W-1:0]     r_rf_addr;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic                r_rf_we;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    op_e                 w_op;
    logic                w_accept;
    state_e              w_next_state;
    logic                w_load_rsp;
    logic [DATA_W-1:0]   w_rsp_data_d;
    status_e             w_rsp_status_d;
    state_e              w_ret_d;
    logic                w_rd_start;
    logic                w_wr_start;
    logic                w_stall;
    logic [DATA_W-1:0]   w_flags_ext;

    assign w_op        = op_e'(cmd_op);
    assign w_flags_ext = {{(DATA_W-FLAGS_W){1'b0}}, flags};

    // Commands are taken only in the two resting states; r_live keeps
    // cmd_ready low while reset is held and for the first edge after it.
    assign cmd_ready = r_live && ((r_state == S_RUN) || (r_state == S_HALTED));
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_next_state   = r_state;
        w_load_rsp     = 1'b0;
        w_rsp_data_d   = '0;
        w_rsp_status_d = STAT_OK;
        w_ret_d        = r_state;
        w_rd_start     = 1'b0;
        w_wr_start     = 1'b0;
        w_stall        = 1'b0;

        case (r_state)
            S_RUN, S_HALTED: begin
                w_stall = (r_state == S_HALTED);
                if (w_accept) begin
                    if (needs_halt(w_op) && (r_state == S_RUN)) begin
                        // Refused without touching the CPU or register file.
                        w_load_rsp     = 1'b1;
                        w_rsp_status_d = STAT_NOT_HALTED;
                        w_ret_d        = S_RUN;
                        w_next_state   = S_RESP;
                    end else begin
                        case (w_op)
                            OP_HALT: begin
                                if (r_state == S_RUN) begin
                                    // Response is produced once the CPU reaches a boundary.
                                    w_next_state = S_HALT_PEND;
                                end else begin
                                    w_load_rsp   = 1'b1;
                                    w_ret_d      = S_HALTED;
                                    w_next_state = S_RESP;
                                end
                            end
                            OP_RESUME: begin
                                w_load_rsp   = 1'b1;
                                w_ret_d      = S_RUN;
                                w_next_state = S_RESP;
                            end
                            OP_STEP: begin
                                w_next_state = S_STEP_REL;
                            end
                            OP_RDREG: begin
                                w_rd_start   = 1'b1;
                                w_next_state = S_RD_WAIT;
                            end
                            OP_WRREG: begin
                                w_wr_start   = 1'b1;
                                w_load_rsp   = 1'b1;
                                w_ret_d      = S_HALTED;
                                w_next_state = S_RESP;
                            end
                            OP_RDPC: begin
                                w_load_rsp   = 1'b1;
                                w_rsp_data_d = pc;
                                w_next_state = S_RESP;
                            end
                            OP_RDIR: begin
                                w_load_rsp   = 1'b1;
                                w_rsp_data_d = ir;
                                w_next_state = S_RESP;
                            end
                            OP_RDFLAGS: begin
                                w_load_rsp   = 1'b1;
                                w_rsp_data_d = w_flags_ext;
                                w_next_state = S_RESP;
                            end
                            default: begin
                                w_load_rsp     = 1'b1;
                                w_rsp_status_d = STAT_BAD_OP;
                                w_next_state   = S_RESP;
                            end
                        endcase
                    end
                end
            end

            S_HALT_PEND: begin
                // Stall exactly on the fetch strobe so the CPU freezes on a boundary.
                w_stall = ir_enable;
                if (ir_enable) begin
                    w_load_rsp   = 1'b1;
                    w_ret_d      = S_HALTED;
                    w_next_state = S_RESP;
                end
            end

            S_STEP_REL: begin
                // One free cycle lets the CPU take the fetch it was held on.
                w_stall      = 1'b0;
                w_next_state = S_STEP_WAIT;
            end

            S_STEP_WAIT: begin
                w_stall = ir_enable;
                if (ir_enable) begin
                    w_load_rsp   = 1'b1;
                    w_ret_d      = S_HALTED;
                    w_next_state = S_RESP;
                end
            end

            S_RD_WAIT: begin
                // rf_rdata now reflects the address presented on the accept cycle.
                w_stall      = 1'b1;
                w_load_rsp   = 1'b1;
                w_rsp_data_d = rf_rdata;
                w_ret_d      = S_HALTED;
                w_next_state = S_RESP;
            end

            S_RESP: begin
                w_stall = (r_ret == S_HALTED);
                if (rsp_ready) begin
                    w_next_state = r_ret;
                end
            end

            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_live  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response register: loaded once per command, held through RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_data   <= '0;
            r_rsp_status <= 2'b00;
            r_ret        <= S_RUN;
        end else if (w_load_rsp) begin
            r_rsp_data   <= w_rsp_data_d;
            r_rsp_status <= w_rsp_status_d;
            r_ret        <= w_ret_d;
        end
    end

    // ------------------------------------------------------------------
    // Register-file debug port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_rf_we    <= 1'b0;
        end else begin
            // Write strobe lives for the single cycle after a WRREG is taken.
            r_rf_we <= w_wr_start;
            if (w_rd_start || w_wr_start) begin
                r_rf_addr <= cmd_addr;
            end
            if (w_wr_start) begin
                r_rf_wdata <= cmd_data;
            end
        end
    end

    // The read address is presented on the accept cycle itself so the
    // one-cycle synchronous read lands during RD_WAIT.
    assign rf_addr    = (w_rd_start || w_wr_start) ? cmd_addr : r_rf_addr;
    assign rf_wdata   = r_rf_wdata;
    assign rf_we      = r_rf_we;

    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
    assign cpu_stall  = w_stall;

endmodule

// File: tb/tb_debug_ctrl.sv
// tb/tb_debug_ctrl.sv - self-checking bench for debug_ctrl

module tb_debug_ctrl;

    localparam logic [2:0] C_HALT    = 3'd0;
    localparam logic [2:0] C_RESUME  = 3'd1;
    localparam logic [2:0] C_STEP    = 3'd2;
    localparam logic [2:0] C_RDREG   = 3'd3;
    localparam logic [2:0] C_WRREG   = 3'd4;
    localparam logic [2:0] C_RDPC    = 3'd5;
    localparam logic [2:0] C_RDIR    = 3'd6;
    localparam logic [2:0] C_RDFLAGS = 3'd7;
    localparam logic [1:0] C_OK      = 2'b00;
    localparam logic [1:0] C_NH      = 2'b01;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        ir_enable;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [3:0]  flags;
    logic        cpu_stall;
    logic [3:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic        rf_we;
    logic [15:0] rf_rdata;

    debug_ctrl #(.DATA_W(16), .RA_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .ir_enable(ir_enable), .ir(ir), .pc(pc), .flags(flags),
        .cpu_stall(cpu_stall),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
    );

    // CPU model: asserts ir_enable on a fetch cycle and holds it there while
    // stalled; each unstalled fetch retires one instruction (pc+1) followed
    // by 0..3 execute cycles. ir is a fixed function of pc.
    logic        cpu_auto;
    logic        ir_manual;
    logic        cpu_set;
    logic [15:0] cpu_set_val;
    logic [15:0] pc_q;
    logic [1:0]  cpu_cnt;

    always @(posedge clk) begin
        if (cpu_set) begin
            pc_q    <= cpu_set_val;
            cpu_cnt <= 2'd0;
        end else if (ir_enable && !cpu_stall) begin
            pc_q    <= pc_q + 16'd1;
            cpu_cnt <= 2'($urandom_range(0, 3));
        end else if (cpu_cnt != 2'd0) begin
            cpu_cnt <= cpu_cnt - 2'd1;
        end
    end
    assign pc        = pc_q;
    assign ir        = pc_q ^ 16'h5A00;
    assign ir_enable = cpu_auto ? (cpu_cnt == 2'd0) : ir_manual;

    logic       flags_rand;
    logic [3:0] flags_fixed;
    always @(posedge clk) flags <= flags_rand ? 4'($urandom) : flags_fixed;

    // Register file with one-cycle synchronous read.
    logic [15:0] rf_mem [16];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 16'h1000 + 16'(i);
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
        rf_rdata <= rf_mem[rf_addr];
    end

    int we_cnt = 0;
    always @(posedge clk) if (rf_we === 1'b1) we_cnt <= we_cnt + 1;

    int total = 0;
    int bad   = 0;

    logic [15:0] s_pc, s_ir;
    logic [3:0]  s_flags;
    logic [15:0] m_regs [16];

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  e_st;
        logic [15:0] e_data;
        int          e_we;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h1000 + 16'(i);
    endtask

    task automatic set_pc(input logic [15:0] v);
        cpu_set_val = v;
        cpu_set     = 1'b1;
        @(negedge clk);
        cpu_set     = 1'b0;
    endtask

    // Called and returns on a falling edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [15:0] d);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_ready_timeout: op %0d not accepted, cmd_ready=%b required 1", op, cmd_ready);
        end else begin
            s_pc      = pc;
            s_ir      = ir;
            s_flags   = flags;
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_addr  = a;
            cmd_data  = d;
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op    = 3'd0;
            cmd_addr  = 4'd0;
            cmd_data  = 16'd0;
        end
    endtask

    task automatic collect(output logic [15:0] d, output logic [1:0] st);
        int n;
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
            d  = 16'hDEAD;
            st = 2'b11;
        end else begin
            d         = rsp_data;
            st        = rsp_status;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output logic [1:0] st);
        issue(op, a, d);
        collect(rd, st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd, e_d, h_pc;
        logic [1:0]  st, e_st;
        logic [2:0]  op;
        logic [3:0]  a;
        logic [15:0] d;
        logic        m_halted, seen;
        int          w0, e_we, errs;

        tbl[0]  = '{C_RDREG,   4'd1,  16'h0000, C_NH, 16'h0000, 0};
        tbl[1]  = '{C_WRREG,   4'd2,  16'h1234, C_NH, 16'h0000, 0};
        tbl[2]  = '{C_STEP,    4'd0,  16'h0000, C_NH, 16'h0000, 0};
        tbl[3]  = '{C_RESUME,  4'd0,  16'h0000, C_OK, 16'h0000, 0};
        tbl[4]  = '{C_RDFLAGS, 4'd0,  16'hFFFF, C_OK, 16'h000A, 0};
        tbl[5]  = '{C_HALT,    4'd0,  16'h0000, C_OK, 16'h0000, 0};
        tbl[6]  = '{C_HALT,    4'd0,  16'h0000, C_OK, 16'h0000, 0};
        tbl[7]  = '{C_WRREG,   4'd3,  16'hBEEF, C_OK, 16'h0000, 1};
        tbl[8]  = '{C_RDREG,   4'd3,  16'h0000, C_OK, 16'hBEEF, 0};
        tbl[9]  = '{C_WRREG,   4'd15, 16'h1234, C_OK, 16'h0000, 1};
        tbl[10] = '{C_RDREG,   4'd15, 16'h0000, C_OK, 16'h1234, 0};
        tbl[11] = '{C_RDREG,   4'd2,  16'h0000, C_OK, 16'h1002, 0};
        tbl[12] = '{C_RDFLAGS, 4'd0,  16'h0000, C_OK, 16'h000A, 0};
        tbl[13] = '{C_RESUME,  4'd0,  16'h0000, C_OK, 16'h0000, 0};

        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_addr    = 4'd0;
        cmd_data    = 16'd0;
        rsp_ready   = 1'b0;
        cpu_auto    = 1'b0;
        ir_manual   = 1'b0;
        cpu_set     = 1'b1;
        cpu_set_val = 16'h0100;
        flags_rand  = 1'b0;
        flags_fixed = 4'hA;
        model_reset();

        // Reset values and cmd_ready release timing.
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {cpu_stall, cmd_ready, rsp_valid, rf_we, rsp_status, rf_addr}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        cpu_set = 1'b0;
        reset_n = 1'b1;
        #1 chk("cmd_ready_at_release", cmd_ready, 32'd0);
        @(negedge clk);
        chk("cmd_ready_after_release", cmd_ready, 32'd1);

        // Table-driven command vectors.
        cpu_auto = 1'b1;
        for (int i = 0; i < 14; i++) begin
            w0 = we_cnt;
            do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, rd, st);
            chk($sformatf("tbl%0d_status", i), st, tbl[i].e_st);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].e_data);
            chk($sformatf("tbl%0d_rf_we", i), we_cnt - w0, tbl[i].e_we);
        end

        // Halt while running, fetch strobe four cycles later.
        cpu_auto  = 1'b0;
        ir_manual = 1'b0;
        set_pc(16'h0010);
        issue(C_HALT, 4'd0, 16'd0);
        seen = 1'b0;
        repeat (3) begin
            seen |= cpu_stall;
            @(negedge clk);
        end
        seen |= cpu_stall;
        chk("halt_pend_no_stall", seen, 32'd0);
        ir_manual = 1'b1;
        #1 chk("halt_pend_stall_on_ir", cpu_stall, 32'd1);
        @(negedge clk);
        ir_manual = 1'b0;
        collect(rd, st);
        chk("halt_status", st, C_OK);
        chk("halted_stall", cpu_stall, 32'd1);
        repeat (2) @(negedge clk);
        do_cmd(C_RDPC, 4'd0, 16'd0, rd, st);
        chk("halt_rdpc", rd, 32'h0010);

        // Single step with the next fetch three cycles later.
        ir_manual = 1'b1;
        @(negedge clk);
        issue(C_STEP, 4'd0, 16'd0);
        chk("step_rel_stall_low", cpu_stall, 32'd0);
        @(negedge clk);
        ir_manual = 1'b0;
        repeat (2) @(negedge clk);
        ir_manual = 1'b1;
        #1 chk("step_wait_stall_on_ir", cpu_stall, 32'd1);
        @(negedge clk);
        collect(rd, st);
        chk("step_status", st, C_OK);
        chk("step_pc_plus_one", pc, 32'h0011);
        do_cmd(C_RDIR, 4'd0, 16'd0, rd, st);
        chk("step_rdir", rd, 32'h5A11);

        // Response held while the host is not ready.
        issue(C_RDFLAGS, 4'd0, 16'd0);
        errs = 0;
        repeat (5) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h000A || rsp_status !== C_OK || cmd_ready !== 1'b0)
                errs++;
            @(negedge clk);
        end
        chk("rsp_hold_stable", errs, 32'd0);
        collect(rd, st);
        chk("rsp_hold_data", rd, 32'h000A);

        // Reset in the middle of a step, on a stalling fetch cycle.
        ir_manual = 1'b0;
        issue(C_STEP, 4'd0, 16'd0);
        @(negedge clk);
        ir_manual = 1'b1;
        reset_n   = 1'b0;
        #1 chk("reset_midstep", {cpu_stall, rsp_valid, cmd_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (3) begin
            seen |= rsp_valid;
            @(negedge clk);
        end
        chk("no_rsp_after_reset", seen, 32'd0);
        do_cmd(C_STEP, 4'd0, 16'd0, rd, st);
        chk("run_after_reset", st, C_NH);

        // Randomised commands against a transaction-level model.
        cpu_auto   = 1'b1;
        flags_rand = 1'b1;
        m_halted   = 1'b0;
        h_pc       = 16'd0;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom);
            d  = 16'($urandom);
            w0 = we_cnt;
            do_cmd(op, a, d, rd, st);
            e_st = C_OK;
            e_d  = 16'd0;
            e_we = 0;
            case (op)
                C_HALT: begin
                    if (!m_halted) h_pc = pc;
                    m_halted = 1'b1;
                end
                C_RESUME: m_halted = 1'b0;
                C_STEP: begin
                    if (!m_halted) e_st = C_NH;
                    else           h_pc = h_pc + 16'd1;
                end
                C_RDREG: begin
                    if (!m_halted) e_st = C_NH;
                    else           e_d  = m_regs[a];
                end
                C_WRREG: begin
                    if (!m_halted) begin
                        e_st = C_NH;
                    end else begin
                        m_regs[a] = d;
                        e_we      = 1;
                    end
                end
                C_RDPC:    e_d = m_halted ? h_pc : s_pc;
                C_RDIR:    e_d = m_halted ? (h_pc ^ 16'h5A00) : s_ir;
                default:   e_d = {12'h000, s_flags};
            endcase
            chk($sformatf("rand%0d_op%0d_status", i, op), st, e_st);
            chk($sformatf("rand%0d_op%0d_data", i, op), rd, e_d);
            chk($sformatf("rand%0d_op%0d_rf_we", i, op), we_cnt - w0, e_we);
            if (m_halted) chk($sformatf("rand%0d_pc_frozen", i), pc, h_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
